// File: rtl/i2c_arb_pkg.sv
// Shared types and default sizing for the I2C transaction arbiter.
// Used by i2c_txn_arbiter and rr_picker.
package i2c_arb_pkg;

    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ISSUE_TMO = 64;
    localparam int DEF_MAX_RETRY = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: the first active request at or after ptr_i wins.
// Returns the winner one-hot, its index, and whether any request was present.
module rr_picker
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [PTR_W-1:0] sel;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sel     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!valid_o && req_i[sel]) begin
                valid_o    = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = sel;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ single-byte requesters.
// Optional feature: define I2C_RETRY_EN to re-issue NACKed transactions up to MAX_RETRY times.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ISSUE_TMO = DEF_ISSUE_TMO,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      ctl_new_data,
    output logic                      ctl_rw,
    output logic [ADDR_W-1:0]         ctl_addr,
    output logic [DATA_W-1:0]         ctl_data_in,
    input  logic [DATA_W-1:0]         ctl_data_out,
    input  logic                      ctl_bus_busy,
    input  logic                      ctl_done,
    input  logic                      ctl_ack_error
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(ISSUE_TMO + 1);

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`ifdef I2C_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0]  retry_q, retry_d;
`endif

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
`ifdef I2C_RETRY_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef I2C_RETRY_EN
                retry_d = '0;
`endif
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    win_d   = pick_idx;
                    rw_d    = req_rw[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tmo_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                // A controller that never goes busy must not stall the other requesters.
                if (ctl_bus_busy) begin
                    state_d = WAIT;
                end else if (tmo_q == TMO_W'(ISSUE_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT: begin
`ifdef I2C_RETRY_EN
                if (ctl_done && ctl_ack_error && (retry_q < RETRY_W'(MAX_RETRY))) begin
                    retry_d = retry_q + 1'b1;
                    state_d = LOAD;
                end else if (ctl_done) begin
                    rdata_d = ctl_data_out;
                    err_d   = ctl_ack_error;
                    state_d = RESP;
                end
`else
                if (ctl_done) begin
                    rdata_d = ctl_data_out;
                    err_d   = ctl_ack_error;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
`ifdef I2C_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`ifdef I2C_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = (state_q == RESP) ? gnt_q : '0;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign ctl_new_data = (state_q == ISSUE);
    assign ctl_rw       = rw_q;
    assign ctl_addr     = addr_q;
    assign ctl_data_in  = wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed testbench for i2c_txn_arbiter with a behavioural i2c_controller stub.
// Expectations for the NACK scenario follow whether I2C_RETRY_EN is defined.
module tb_i2c_txn_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ctl_new_data;
    logic        ctl_rw;
    logic [6:0]  ctl_addr;
    logic [7:0]  ctl_data_in;
    logic [7:0]  ctl_data_out;
    logic        ctl_bus_busy;
    logic        ctl_done;
    logic        ctl_ack_error;

    int checks = 0;
    int errors = 0;

    // Controller stub knobs
    int         stubBusyDelay = 3;
    int         stubDoneDelay = 5;
    bit         stubNeverBusy = 0;
    bit         stubStrayAck  = 0;
    logic [7:0] stubNackMask  = 8'h00;
    logic [7:0] stubRdata     = 8'h00;
    int         stubAttempts  = 0;

    // Monitor state
    int   grantLog[$];
    int   overlapErrs  = 0;
    int   widthErrs    = 0;
    int   ndHighCycles = 0;
    int   ndPulses     = 0;
    int   rspEvents    = 0;
    logic [3:0] prevGnt = '0;
    logic [3:0] prevRsp = '0;
    logic       prevNd  = 1'b0;

    i2c_txn_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_rw        (req_rw),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .ctl_new_data  (ctl_new_data),
        .ctl_rw        (ctl_rw),
        .ctl_addr      (ctl_addr),
        .ctl_data_in   (ctl_data_in),
        .ctl_data_out  (ctl_data_out),
        .ctl_bus_busy  (ctl_bus_busy),
        .ctl_done      (ctl_done),
        .ctl_ack_error (ctl_ack_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ohIdx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Stub: answers each new_data with busy after stubBusyDelay cycles and done after stubDoneDelay more
    initial begin
        ctl_bus_busy  = 1'b0;
        ctl_done      = 1'b0;
        ctl_ack_error = 1'b0;
        ctl_data_out  = 8'h00;
        forever begin
            @(negedge clk);
            if (ctl_new_data && !stubNeverBusy) begin
                repeat (stubBusyDelay) @(negedge clk);
                ctl_bus_busy = 1'b1;
                for (int c = 0; c < stubDoneDelay; c++) begin
                    @(negedge clk);
                    ctl_ack_error = stubStrayAck && (c == 1);
                end
                ctl_done      = 1'b1;
                ctl_data_out  = stubRdata;
                ctl_ack_error = stubNackMask[stubAttempts[2:0]];
                stubAttempts++;
                @(negedge clk);
                ctl_done      = 1'b0;
                ctl_ack_error = 1'b0;
                ctl_bus_busy  = 1'b0;
            end
        end
    end

    // Bus monitor: grant order, overlap, pulse widths, new_data activity
    always @(negedge clk) begin
        if ($countones(gnt) > 1) overlapErrs++;
        if ((rsp_valid & prevRsp) != 4'b0000) widthErrs++;
        if (gnt != 4'b0000 && prevGnt == 4'b0000) grantLog.push_back(ohIdx(gnt));
        if (ctl_new_data) ndHighCycles++;
        if (ctl_new_data && !prevNd) ndPulses++;
        if (rsp_valid != 4'b0000) rspEvents++;
        prevGnt = gnt;
        prevRsp = rsp_valid;
        prevNd  = ctl_new_data;
    end

    task automatic setReq(input int idx, input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
        req_rw[idx]             = rw;
        req_addr[idx*7 +: 7]    = addr;
        req_wdata[idx*8 +: 8]   = wdata;
    endtask

    // kind: 0 rsp_valid, 1 ctl_new_data, 2 gnt, 3 ctl_bus_busy
    task automatic waitCond(input int kind, input int maxCycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if ((kind == 0 && rsp_valid != 4'b0000) || (kind == 1 && ctl_new_data) ||
                (kind == 2 && gnt != 4'b0000) || (kind == 3 && ctl_bus_busy)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req = 4'b0000; req_rw = '0; req_addr = '0; req_wdata = '0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) setReq(i, 1'b0, 7'h10 + 7'(i), 8'h20 + 8'(i));
        req = 4'b1111;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++; if (ctl_new_data !== 1'b0) begin errors++; $display("[TB] FAIL reset_new_data got=%b exp=0", ctl_new_data); end
        checks++; if (ctl_addr !== 7'h00) begin errors++; $display("[TB] FAIL reset_ctl_addr got=%h exp=00", ctl_addr); end
        checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rsp got err=%b rdata=%h exp 0/00", rsp_err, rsp_rdata); end
    endtask

    task automatic test_contention();
        int seen;
        bit ok;
        int expOrder[5] = '{0, 1, 2, 3, 0};
        stubBusyDelay = 3; stubDoneDelay = 5;
        grantLog.delete();
        rst_n = 1'b1;
        seen = 0;
        while (seen < 5) begin
            waitCond(0, 200, ok);
            if (!ok) begin
                checks++; errors++;
                $display("[TB] FAIL contention_timeout got=%0d responses exp=5", seen);
                break;
            end
            seen++;
            if (seen == 5) req = 4'b0000;
        end
        repeat (3) @(negedge clk);
        checks++; if (grantLog.size() != 5) begin errors++; $display("[TB] FAIL contention_grants got=%0d exp=5", grantLog.size()); end
        for (int i = 0; i < 5 && i < grantLog.size(); i++) begin
            checks++;
            if (grantLog[i] != expOrder[i]) begin errors++; $display("[TB] FAIL contention_order[%0d] got=%0d exp=%0d", i, grantLog[i], expOrder[i]); end
        end
        checks++; if (overlapErrs != 0) begin errors++; $display("[TB] FAIL gnt_overlap got=%0d exp=0", overlapErrs); end
        checks++; if (widthErrs != 0) begin errors++; $display("[TB] FAIL rsp_width got=%0d exp=0", widthErrs); end
    endtask

    task automatic test_single_write();
        bit ok;
        stubBusyDelay = 3; stubDoneDelay = 40;
        setReq(0, 1'b0, 7'h6D, 8'hA5);
        req = 4'b0001;
        waitCond(1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL write_new_data got=timeout exp=asserted"); end
        else if (ctl_addr !== 7'h6D || ctl_data_in !== 8'hA5 || ctl_rw !== 1'b0) begin
            errors++; $display("[TB] FAIL write_ctl got addr=%h data=%h rw=%b exp 6D/A5/0", ctl_addr, ctl_data_in, ctl_rw);
        end
        waitCond(0, 200, ok);
        req = 4'b0000;
        checks++; if (!ok || rsp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL write_rsp_valid got=%b exp=0001", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL write_rsp_err got=%b exp=0", rsp_err); end
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("[TB] FAIL write_release got rsp=%b gnt=%b exp 0000/0000", rsp_valid, gnt); end
    endtask

    task automatic test_read();
        bit ok;
        stubBusyDelay = 3; stubDoneDelay = 6; stubRdata = 8'h3C; stubStrayAck = 1'b1;
        setReq(2, 1'b1, 7'h50, 8'h00);
        req = 4'b0100;
        waitCond(1, 50, ok);
        checks++;
        if (!ok || ctl_rw !== 1'b1 || ctl_addr !== 7'h50) begin
            errors++; $display("[TB] FAIL read_ctl got rw=%b addr=%h exp 1/50", ctl_rw, ctl_addr);
        end
        waitCond(0, 200, ok);
        req = 4'b0000;
        checks++; if (!ok || rsp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL read_rsp_valid got=%b exp=0100", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("[TB] FAIL read_rdata got=%h exp=3C", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL read_stray_ack got err=%b exp=0", rsp_err); end
        stubStrayAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic runNack(input logic [7:0] mask, input int expAttempts, input logic expErr, input string tag);
        bit ok;
        stubBusyDelay = 3; stubDoneDelay = 5; stubNackMask = mask;
        stubAttempts = 0; ndPulses = 0;
        setReq(1, 1'b0, 7'h2A, 8'h5A);
        req = 4'b0010;
        waitCond(0, 300, ok);
        req = 4'b0000;
        checks++; if (!ok || rsp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL %s_rsp_valid got=%b exp=0010", tag, rsp_valid); end
        checks++; if (rsp_err !== expErr) begin errors++; $display("[TB] FAIL %s_err got=%b exp=%b", tag, rsp_err, expErr); end
        checks++; if (ndPulses != expAttempts) begin errors++; $display("[TB] FAIL %s_new_data_pulses got=%0d exp=%0d", tag, ndPulses, expAttempts); end
        stubNackMask = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nack();
`ifdef I2C_RETRY_EN
        runNack(8'hFF, 3, 1'b1, "nack_all");
        runNack(8'h01, 2, 1'b0, "nack_first");
`else
        runNack(8'hFF, 1, 1'b1, "nack_all");
        runNack(8'h01, 1, 1'b1, "nack_first");
`endif
    endtask

    task automatic test_timeout();
        bit ok;
        stubNeverBusy = 1'b1; stubRdata = 8'h77;
        ndHighCycles = 0;
        setReq(3, 1'b0, 7'h33, 8'h44);
        setReq(0, 1'b1, 7'h11, 8'h00);
        req = 4'b1001;
        waitCond(0, 200, ok);
        req = 4'b0001;
        stubNeverBusy = 1'b0;
        checks++; if (!ok || rsp_valid !== 4'b1000) begin errors++; $display("[TB] FAIL tmo_rsp_valid got=%b exp=1000", rsp_valid); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err got=%b exp=1", rsp_err); end
        checks++; if (ndHighCycles != 64) begin errors++; $display("[TB] FAIL tmo_new_data_cycles got=%0d exp=64", ndHighCycles); end
        waitCond(2, 10, ok);
        checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("[TB] FAIL tmo_next_gnt got=%b exp=0001", gnt); end
        waitCond(0, 200, ok);
        req = 4'b0000;
        checks++; if (!ok || rsp_err !== 1'b0 || rsp_rdata !== 8'h77) begin errors++; $display("[TB] FAIL tmo_next_rsp got err=%b rdata=%h exp 0/77", rsp_err, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int rspBefore;
        stubBusyDelay = 3; stubDoneDelay = 40;
        setReq(2, 1'b0, 7'h4E, 8'h99);
        req = 4'b0100;
        waitCond(3, 50, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_reach_wait got=timeout exp=busy"); end
        repeat (5) @(negedge clk);
        rspBefore = rspEvents;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rst_async_gnt got gnt=%b rsp=%b exp 0000/0000", gnt, rsp_valid); end
        checks++; if (ctl_addr !== 7'h00 || ctl_data_in !== 8'h00 || ctl_new_data !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_async_ctl got addr=%h data=%h nd=%b exp 00/00/0", ctl_addr, ctl_data_in, ctl_new_data);
        end
        checks++; if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_rsp got rdata=%h err=%b exp 00/0", rsp_rdata, rsp_err); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (rspEvents != rspBefore) begin errors++; $display("[TB] FAIL rst_no_rsp got=%0d exp=%0d", rspEvents, rspBefore); end
        // ptr was 1 before reset; after reset requester 0 must beat requester 3
        stubBusyDelay = 3; stubDoneDelay = 5;
        req = 4'b1001;
        waitCond(2, 10, ok);
        checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rst_ptr_gnt got=%b exp=0001", gnt); end
        waitCond(0, 200, ok);
        req = 4'b0000;
        checks++; if (!ok || rsp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL rst_after_rsp got=%b exp=0001", rsp_valid); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_read();
        test_nack();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=expired exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
